// File: rtl/updown_sweep_ctrl.sv
// Direction/enable sequencer for a WIDTH-bit up/down counter: sweeps the count
// between captured low/high limits, dwelling DWELL cycles at each turn, for SWEEPS sweeps.
module updown_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DWELL  = 2,
  parameter int SWEEPS = 3,
  parameter int SCW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  input  logic [WIDTH-1:0] count_in,
  output logic             updown,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [SCW-1:0]   sweep_cnt,
  output logic [2:0]       state_dbg
);

  localparam int TW = $clog2(DWELL) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo_r, hi_r, lo_nxt, hi_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [SCW-1:0]   sweep_nxt, sweep_inc;
  logic             busy_nxt, done_nxt, cfg_err_nxt;
  logic             dwell_end;

  assign dwell_end = (timer == TW'(DWELL - 1));
  assign sweep_inc = sweep_cnt + SCW'(1);
  assign state_dbg = state;

  // Handshake: start is a level sampled only in IDLE; an accepted start raises
  // busy on the same edge, done/cfg_err are single-cycle registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lo_r      <= '0;
      hi_r      <= '0;
      timer     <= '0;
      sweep_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lo_r      <= lo_nxt;
      hi_r      <= hi_nxt;
      timer     <= timer_nxt;
      sweep_cnt <= sweep_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cfg_err   <= cfg_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lo_nxt      = lo_r;
    hi_nxt      = hi_r;
    timer_nxt   = timer;
    sweep_nxt   = sweep_cnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    cfg_err_nxt = 1'b0;
    updown      = 1'b1;
    cnt_en      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (lo_lim < hi_lim) begin
            lo_nxt    = lo_lim;
            hi_nxt    = hi_lim;
            sweep_nxt = '0;
            busy_nxt  = 1'b1;
            state_nxt = S_UP;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end

      // Enable drops in the cycle the limit is seen, so the counter never overshoots.
      S_UP: begin
        updown = 1'b1;
        cnt_en = (count_in < hi_r);
        if (count_in >= hi_r) begin
          timer_nxt = '0;
          state_nxt = S_HOLD_HI;
        end
      end

      S_HOLD_HI: begin
        updown = 1'b0;
        if (dwell_end) begin
          timer_nxt = '0;
          state_nxt = S_DOWN;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      S_DOWN: begin
        updown = 1'b0;
        cnt_en = (count_in > lo_r);
        if (count_in <= lo_r) begin
          sweep_nxt = sweep_inc;
          timer_nxt = '0;
          state_nxt = (sweep_inc == SCW'(SWEEPS)) ? S_DONE : S_HOLD_LO;
        end
      end

      S_HOLD_LO: begin
        updown = 1'b1;
        if (dwell_end) begin
          timer_nxt = '0;
          state_nxt = S_UP;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      S_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a start or limit hit in the same cycle.
    if (abort) begin
      cnt_en      = 1'b0;
      state_nxt   = S_IDLE;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
      cfg_err_nxt = 1'b0;
      timer_nxt   = '0;
      lo_nxt      = lo_r;
      hi_nxt      = hi_r;
      sweep_nxt   = sweep_cnt;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a behavioural up/down counter closes the loop and
// a trace model built from the sweep rules predicts every cycle of each run.
module tb_updown_sweep_ctrl;

  localparam int W      = 4;
  localparam int DWELL  = 2;
  localparam int SWEEPS = 3;
  localparam int SCW    = 4;
  localparam int EW     = W + 5 + SCW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W-1:0]   lo_lim = '0;
  logic [W-1:0]   hi_lim = '0;
  logic [W-1:0]   count_in;
  logic           updown, cnt_en, busy, done, cfg_err;
  logic [SCW-1:0] sweep_cnt;
  logic [2:0]     state_dbg;

  logic           ld = 1'b0;
  logic [W-1:0]   ld_val = '0;
  logic [W-1:0]   cnt = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle trace: {count, cnt_en, updown, busy, done, cfg_err, sweep_cnt}
  logic [EW-1:0] exp_q[$];

  updown_sweep_ctrl #(.WIDTH(W), .DWELL(DWELL), .SWEEPS(SWEEPS), .SCW(SCW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .count_in(count_in),
    .updown(updown), .cnt_en(cnt_en), .busy(busy), .done(done),
    .cfg_err(cfg_err), .sweep_cnt(sweep_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / downstream counter ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) cnt <= ld_val;
    else if (cnt_en) cnt <= updown ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign count_in = cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; ld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  task automatic push(input int c, input bit en, input bit ud, input bit b, input bit d, input int sw);
    exp_q.push_back({W'(c), en, ud, b, d, 1'b0, SCW'(sw)});
  endtask

  // One full run from count c0 with limits lo<hi, starting the cycle after acceptance.
  task automatic build_run(input int c0, input int lo, input int hi);
    int c;
    c = c0;
    for (int s = 0; s < SWEEPS; s++) begin
      while (c < hi) begin push(c, 1, 1, 1, 0, s); c++; end
      push(c, 0, 1, 1, 0, s);
      repeat (DWELL) push(c, 0, 0, 1, 0, s);
      while (c > lo) begin push(c, 1, 0, 1, 0, s); c--; end
      push(c, 0, 0, 1, 0, s);
      if (s == SWEEPS - 1) begin
        push(c, 0, 1, 1, 0, s + 1);
        push(c, 0, 1, 0, 1, s + 1);
      end else begin
        repeat (DWELL) push(c, 0, 1, 1, 0, s + 1);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic kick(input int c0, input int lo, input int hi, input bit hold);
    ld = 1'b1; ld_val = W'(c0); lo_lim = W'(lo); hi_lim = W'(hi);
    @(negedge clk);
    ld = 1'b0; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic check_trace(input string name, input int n, input bit scramble);
    logic [EW-1:0] e, got;
    for (int i = 0; i < n; i++) begin
      e   = exp_q.pop_front();
      got = {count_in, cnt_en, updown, busy, done, cfg_err, sweep_cnt};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got cnt=%0d en=%b ud=%b busy=%b done=%b cfg=%b sw=%0d, expected cnt=%0d en=%b ud=%b busy=%b done=%b cfg=%b sw=%0d",
                 name, i, got[EW-1 -: W], got[SCW+4], got[SCW+3], got[SCW+2], got[SCW+1], got[SCW], got[SCW-1:0],
                 e[EW-1 -: W], e[SCW+4], e[SCW+3], e[SCW+2], e[SCW+1], e[SCW], e[SCW-1:0]);
      end
      if (scramble) begin lo_lim = W'($urandom); hi_lim = W'($urandom); end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, cfg_err, cnt_en, updown, sweep_cnt} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SCW'(0)}) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b cfg=%b en=%b ud=%b sw=%0d, expected 0 0 0 0 1 0",
               busy, done, cfg_err, cnt_en, updown, sweep_cnt);
    end
    do_reset();
    n_tests++;
    if ({busy, cnt_en, updown} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b en=%b ud=%b, expected 0 0 1", busy, cnt_en, updown);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    exp_q.delete();
    build_run(0, 2, 9);
    kick(0, 2, 9, 0);
    check_trace("nominal", exp_q.size(), 0);
    n_tests++;
    if (count_in !== W'(2) || done !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_end: got count=%0d done=%b, expected count=2 done=0", count_in, done);
    end
  endtask

  task automatic test_bad_config();
    int los[2] = '{9, 5};
    int his[2] = '{2, 5};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      lo_lim = W'(los[k]); hi_lim = W'(his[k]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if ({cfg_err, busy, cnt_en, updown} !== 4'b1001) begin
        n_fail++;
        $display("FAIL bad_cfg_pulse lo=%0d hi=%0d: got cfg=%b busy=%b en=%b ud=%b, expected 1 0 0 1",
                 los[k], his[k], cfg_err, busy, cnt_en, updown);
      end
      @(negedge clk);
      n_tests++;
      if ({cfg_err, busy, cnt_en, updown} !== 4'b0001) begin
        n_fail++;
        $display("FAIL bad_cfg_after lo=%0d hi=%0d: got cfg=%b busy=%b en=%b ud=%b, expected 0 0 0 1",
                 los[k], his[k], cfg_err, busy, cnt_en, updown);
      end
    end
  endtask

  task automatic test_off_range();
    do_reset();
    exp_q.delete();
    build_run(12, 2, 9);
    kick(12, 2, 9, 0);
    check_trace("off_range", exp_q.size(), 0);
  endtask

  task automatic test_abort();
    int idx, hits;
    logic [EW-1:0] e;
    logic [W-1:0] hold_c;
    do_reset();
    exp_q.delete();
    build_run(0, 2, 9);
    idx = 0; hits = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      if (hits < 3 && e[SCW-1:0] == SCW'(1) && e[SCW+3] == 1'b0 && e[SCW+4] == 1'b1) begin
        hits++;
        if (hits == 3) idx = k;
      end
    end
    kick(0, 2, 9, 0);
    check_trace("abort_pre", idx, 0);
    hold_c = exp_q[0][EW-1 -: W];
    abort = 1'b1;
    #1;
    n_tests++;
    if (cnt_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_same_cycle: got en=%b busy=%b, expected en=0 busy=1", cnt_en, busy);
    end
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if ({busy, done, cnt_en, updown, sweep_cnt, count_in} !== {4'b0001, SCW'(1), hold_c}) begin
      n_fail++;
      $display("FAIL abort_next: got busy=%b done=%b en=%b ud=%b sw=%0d cnt=%0d, expected 0 0 0 1 sw=1 cnt=%0d",
               busy, done, cnt_en, updown, sweep_cnt, count_in, hold_c);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || count_in !== hold_c) begin
      n_fail++;
      $display("FAIL abort_no_done: got done=%b cnt=%0d, expected done=0 cnt=%0d", done, count_in, hold_c);
    end
    lo_lim = 4'd1; hi_lim = 4'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_tests++;
    if ({busy, cfg_err, cnt_en, sweep_cnt} !== {3'b000, SCW'(1)}) begin
      n_fail++;
      $display("FAIL abort_beats_start: got busy=%b cfg=%b en=%b sw=%0d, expected 0 0 0 sw=1",
               busy, cfg_err, cnt_en, sweep_cnt);
    end
  endtask

  task automatic test_async_reset();
    int idx;
    logic [EW-1:0] e;
    do_reset();
    exp_q.delete();
    build_run(0, 2, 9);
    idx = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      if (idx < 0 && e[SCW+3] == 1'b0) idx = k;
    end
    kick(0, 2, 9, 0);
    check_trace("rst_pre", idx + 1, 0);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, cfg_err, cnt_en, updown, sweep_cnt} !== {5'b00001, SCW'(0)}) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b cfg=%b en=%b ud=%b sw=%0d, expected 0 0 0 0 1 0",
               busy, done, cfg_err, cnt_en, updown, sweep_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    build_run(9, 1, 12);
    kick(9, 1, 12, 0);
    check_trace("after_reset", exp_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    int n1;
    do_reset();
    exp_q.delete();
    build_run(0, 2, 9);
    n1 = exp_q.size();
    build_run(2, 2, 9);
    kick(0, 2, 9, 1);
    check_trace("b2b_run1", n1, 0);
    start = 1'b0;
    check_trace("b2b_run2", exp_q.size(), 0);
  endtask

  task automatic test_random();
    int lo, hi, c0;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      lo = $urandom_range(0, 14);
      hi = $urandom_range(lo + 1, 15);
      c0 = $urandom_range(0, 15);
      exp_q.delete();
      build_run(c0, lo, hi);
      kick(c0, lo, hi, 0);
      check_trace($sformatf("random%0d lo=%0d hi=%0d c0=%0d", r, lo, hi, c0), exp_q.size(), 1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_config();
    test_off_range();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Direction/enable sequencer placed directly upstream of the 4-bit up/down counter. It drives that counter's `updown` select and a count enable, and reads the counter's output back. On `start` it sweeps the count up to a high limit and dwells there, then sweeps down to a low limit and dwells there. It repeats this for a fixed number of sweeps, then pulses `done`. Typical use is a triangle-wave / scan address generator.

Parameters:
- WIDTH, 4: width of count_in, lo_lim, hi_lim.
- DWELL, 2: cycles held at each limit; legal range ≥1.
- SWEEPS, 3: full up+down sweeps per run; legal range ≥1.
- SCW, 4: width of sweep_cnt; must hold SWEEPS.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: begin run; sampled in IDLE only.
- abort, input, 1: terminate run; highest priority.
- lo_lim, input, WIDTH: low turn point; captured at start.
- hi_lim, input, WIDTH: high turn point; captured at start.
- count_in, input, WIDTH: feedback from counter output.
- updown, output, 1: 1 = count up, 0 = count down; to counter.
- cnt_en, output, 1: counter may step this cycle.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle pulse at run completion.
- cfg_err, output, 1: one-cycle pulse when start is rejected.
- sweep_cnt, output, SCW: completed sweeps in the current run.

Behaviour:
- Reset asserted (reset=0), asynchronous: state=IDLE, lo_r=0, hi_r=0, timer=0, sweep_cnt=0, busy=0, done=0, cfg_err=0. Combinational outputs decode to updown=1, cnt_en=0.
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO, DONE.
- Registered: state, lo_r, hi_r, timer, sweep_cnt, busy, done, cfg_err.
- Combinational (Mealy) outputs:
  - UP: updown=1, cnt_en=(count_in<hi_r).
  - HOLD_HI: updown=0, cnt_en=0.
  - DOWN: updown=0, cnt_en=(count_in>lo_r).
  - HOLD_LO: updown=1, cnt_en=0.
  - IDLE, DONE: updown=1, cnt_en=0.
  - abort=1 forces cnt_en=0 in the same cycle, in any state.
- IDLE:
  - start=1 and lo_lim<hi_lim: capture lo_r/hi_r, sweep_cnt←0, busy←1, next state UP.
  - start=1 and lo_lim≥hi_lim: cfg_err←1 for one cycle, remain IDLE.
- UP: count_in≥hi_r → HOLD_HI, timer←0. Counter never steps past hi_r, because cnt_en is already 0 in that cycle.
- HOLD_HI: timer increments each cycle; at timer==DWELL-1 → DOWN. Total dwell is exactly DWELL cycles.
- DOWN: count_in≤lo_r → sweep_cnt←sweep_cnt+1.
  - If sweep_cnt+1==SWEEPS → DONE.
  - Otherwise → HOLD_LO, timer←0.
- HOLD_LO: as HOLD_HI, then → UP.
- DONE: done←1 for exactly one cycle, busy←0, → IDLE. sweep_cnt holds its final value until the next accepted start.
- Start position: count_in may be anywhere at start.
  - Below hi_r: UP steps toward hi_r.
  - At or above hi_r: immediate transition to HOLD_HI.
  - Below lo_r while in DOWN: immediate turn.
- start while busy=1: ignored, no cfg_err.
- lo_lim/hi_lim changes during a run: no effect.
- abort=1, any state: next state IDLE, busy←0, done stays 0, timer←0. sweep_cnt is retained. Abort has priority over start in the same cycle.
- Simultaneous limit reach and abort: abort wins.
- Arithmetic: all comparisons unsigned WIDTH-bit. Timer width is clog2(DWELL)+1, with no wrap. sweep_cnt has no wrap, because SWEEPS ≤ 2^SCW-1.
- Latency: start to first cnt_en=1 is 1 cycle, i.e. the edge after the start-sampling edge.

Test Plan:
- Nominal run (DWELL=2, SWEEPS=3, lo=2, hi=9, bench up/down counter with enable, initial count 0, one-cycle start):
  - count climbs 0→9 and holds 9 for exactly 2 cycles with cnt_en=0, then falls to 2.
  - sweep_cnt steps 1, 2, 3; 7 steps down and 7 steps up between turns.
  - done pulses once, busy falls on the same edge, count ends at 2.
- Bad config (lo=9, hi=2 with start): cfg_err one-cycle pulse; busy stays 0; cnt_en stays 0; updown stays 1.
- Off-range start (initial count 12, lo=2, hi=9): immediate HOLD_HI; no up steps; first movement is down; count never exceeds 12 and never drops below 2.
- Abort: assert abort mid-way through the second DOWN sweep. Required in the same cycle: cnt_en=0. Required on the next edge: IDLE, busy=0, sweep_cnt=1, no done pulse.
- Async reset: pull reset low mid-HOLD_HI, between clock edges. All outputs go to reset values immediately, without waiting for a clock edge. After release, start is accepted again.
- start held high through a whole run: exactly one run per acceptance. A new run begins the cycle after DONE→IDLE, with sweep_cnt cleared to 0.
